// File: rtl/reg_file_swap.sv
// Multi-port register file with two async read ports, optional write bypass, an m-register tap,
// an optional hardwired-zero r0 and an atomic hardware swap of two registers over three edges.
module reg_file_swap #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned M_IDX    = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] m_out,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] swap_a,
  input  logic [ADDR_W-1:0] swap_b,
  output logic              busy,
  output logic              swap_done
);

  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] M_ADDR = ADDR_W'(M_IDX);

  typedef enum logic [1:0] {IDLE, WRA, WRB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] temp;
  logic [ADDR_W-1:0] sa;
  logic [ADDR_W-1:0] sb;
  logic              wr_ok;

  // True when the address targets a hardwired-zero r0
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // External write takes effect only when idle and not aimed at a hardwired r0
  assign wr_ok = wr_en && (state == IDLE) && !is_zero(wr_addr);

  assign m_out = regs[M_ADDR];

  always_comb begin
    rd1_data = regs[rd1_addr];
    if (is_zero(rd1_addr)) begin
      rd1_data = '0;
    end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd1_addr)) begin
      rd1_data = wr_data;
    end
  end

  always_comb begin
    rd2_data = regs[rd2_addr];
    if (is_zero(rd2_addr)) begin
      rd2_data = '0;
    end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd2_addr)) begin
      rd2_data = wr_data;
    end
  end

  // Storage, external write and swap sequencer; temp captures swap_a before any same-edge write
  always_ff @(posedge clk) begin
    if (reset) begin
      regs      <= '{default: '0};
      temp      <= '0;
      sa        <= '0;
      sb        <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok) begin
            regs[wr_addr] <= wr_data;
          end
          if (swap_req) begin
            sa    <= swap_a;
            sb    <= swap_b;
            temp  <= regs[swap_a];
            state <= WRA;
            busy  <= 1'b1;
          end
        end
        WRA: begin
          if (!is_zero(sa)) begin
            regs[sa] <= regs[sb];
          end
          state <= WRB;
        end
        WRB: begin
          if (!is_zero(sb)) begin
            regs[sb] <= temp;
          end
          state     <= IDLE;
          busy      <= 1'b0;
          swap_done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_swap.sv
// Scoreboard bench for reg_file_swap: stimulus queues expected values, a negedge monitor compares.
module tb_reg_file_swap;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rd1_addr, rd2_addr, wr_addr, swap_a, swap_b;
  logic [15:0] rd1_data, rd2_data, m_out, wr_data;
  logic        wr_en, swap_req, busy, swap_done;

  reg_file_swap dut (
    .clk(clk), .reset(reset),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .m_out(m_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
    .busy(busy), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  // sel: 0 rd1, 1 rd2, 2 m_out, 3 busy, 4 swap_done, 5 swap_done pulse count
  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   errors    = 0;
  int   checks    = 0;
  int   done_seen = 0;

  function automatic void expect_val(input int sel, input logic [15:0] e, input string n);
    chk_t c;
    c.sel  = sel;
    c.exp  = e;
    c.name = n;
    sbq.push_back(c);
  endfunction

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      0:       return rd1_data;
      1:       return rd2_data;
      2:       return m_out;
      3:       return {15'b0, busy};
      4:       return {15'b0, swap_done};
      default: return 16'(done_seen);
    endcase
  endfunction

  // Monitor: counts swap_done pulses, then drains everything queued during this cycle
  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    if (swap_done === 1'b1) done_seen++;
    while (sbq.size() > 0) begin
      c   = sbq.pop_front();
      act = pick(c.sel);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
    rd1_addr = a1;
    rd2_addr = a2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; swap_a = '0; swap_b = '0; rd1_addr = '0; rd2_addr = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // 1. reset state
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(i));
      expect_val(0, 16'h0000, $sformatf("reset_rd1_r%0d", i));
      expect_val(1, 16'h0000, $sformatf("reset_rd2_r%0d", i));
      if (i == 0) begin
        expect_val(2, 16'h0000, "reset_m_out");
        expect_val(3, 16'h0000, "reset_busy");
        expect_val(4, 16'h0000, "reset_swap_done");
      end
      cycle();
    end

    // 2. plain writes and hardwired r0
    for (int i = 1; i < 8; i++) wr(3'(i), 16'(16'h0011 * i));
    for (int i = 1; i < 8; i++) begin
      rd(3'(i), 3'(i));
      expect_val(0, 16'(16'h0011 * i), $sformatf("wr_rd1_r%0d", i));
      expect_val(1, 16'(16'h0011 * i), $sformatf("wr_rd2_r%0d", i));
      cycle();
    end
    rd(3'd0, 3'd3);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    expect_val(0, 16'h0000, "r0_write_no_bypass");
    expect_val(2, 16'h0033, "m_out_r3");
    cycle();
    wr_en = 1'b0;
    expect_val(0, 16'h0000, "r0_after_write");
    cycle();

    // 3. bypass
    rd(3'd5, 3'd4);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    expect_val(0, 16'hBEEF, "bypass_rd1");
    expect_val(1, 16'h0044, "bypass_rd2_other");
    expect_val(2, 16'h0033, "bypass_m_out");
    cycle();
    wr_en = 1'b0;
    expect_val(0, 16'hBEEF, "bypass_committed");
    cycle();

    // 4. swap r3/r4, writes during busy dropped
    wr(3'd3, 16'hAAAA);
    wr(3'd4, 16'h5555);
    rd(3'd3, 3'd4);
    swap_req = 1'b1; swap_a = 3'd3; swap_b = 3'd4;
    expect_val(3, 16'h0000, "swap_pre_busy");
    expect_val(0, 16'hAAAA, "swap_pre_r3");
    expect_val(2, 16'hAAAA, "swap_pre_m");
    cycle();                                   // E0
    swap_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
    rd(3'd7, 3'd3);
    expect_val(3, 16'h0001, "swap_busy_wra");
    expect_val(0, 16'h0077, "swap_no_bypass_wra");
    cycle();                                   // E1
    expect_val(3, 16'h0001, "swap_busy_wrb");
    expect_val(0, 16'h0077, "swap_no_bypass_wrb");
    expect_val(4, 16'h0000, "swap_done_early");
    cycle();                                   // E2
    wr_en = 1'b0;
    rd(3'd3, 3'd4);
    #1;
    checks++;
    if (rd1_data !== 16'h5555) begin
      errors++;
      $display("FAIL direct_swap_r3: got %h expected %h", rd1_data, 16'h5555);
    end
    checks++;
    if (rd2_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL direct_swap_r4: got %h expected %h", rd2_data, 16'hAAAA);
    end
    checks++;
    if (m_out !== 16'h5555) begin
      errors++;
      $display("FAIL direct_swap_m_out: got %h expected %h", m_out, 16'h5555);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL direct_swap_busy: got %b expected 0", busy);
    end
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL direct_swap_done: got %b expected 1", swap_done);
    end
    expect_val(4, 16'h0001, "swap_done_pulse");
    expect_val(3, 16'h0000, "swap_busy_clear");
    expect_val(0, 16'h5555, "swap_r3");
    expect_val(1, 16'hAAAA, "swap_r4");
    expect_val(2, 16'h5555, "swap_m_out");
    cycle();
    rd(3'd7, 3'd7);
    expect_val(4, 16'h0000, "swap_done_one_cycle");
    expect_val(0, 16'h0077, "busy_write_dropped");
    expect_val(5, 16'd1, "done_count_t4");
    cycle();

    // 5. swap_req held through busy, then self-swap
    rd(3'd1, 3'd2);
    swap_req = 1'b1; swap_a = 3'd1; swap_b = 3'd2;
    cycle();                                   // E0
    cycle();                                   // E1
    cycle();                                   // E2
    swap_req = 1'b0;
    expect_val(0, 16'h0022, "held_r1");
    expect_val(1, 16'h0011, "held_r2");
    cycle();
    expect_val(3, 16'h0000, "held_not_queued_busy");
    expect_val(0, 16'h0022, "held_r1_stable");
    expect_val(5, 16'd2, "done_count_t5");
    cycle();
    rd(3'd6, 3'd6);
    swap_req = 1'b1; swap_a = 3'd6; swap_b = 3'd6;
    cycle();
    swap_req = 1'b0;
    cycle();
    cycle();
    expect_val(4, 16'h0001, "self_swap_done");
    expect_val(0, 16'h0066, "self_swap_r6");
    cycle();

    // swap with hardwired r0
    rd(3'd5, 3'd0);
    swap_req = 1'b1; swap_a = 3'd5; swap_b = 3'd0;
    cycle();
    swap_req = 1'b0;
    cycle();
    cycle();
    expect_val(0, 16'h0000, "r0_swap_r5");
    expect_val(1, 16'h0000, "r0_swap_r0");
    expect_val(5, 16'd4, "done_count_r0");
    cycle();

    // 6. reset during WRB
    rd(3'd1, 3'd2);
    swap_req = 1'b1; swap_a = 3'd1; swap_b = 3'd2;
    cycle();                                   // E0
    swap_req = 1'b0;
    cycle();                                   // E1, now WRB
    expect_val(3, 16'h0001, "pre_abort_busy");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    expect_val(3, 16'h0000, "abort_busy");
    expect_val(4, 16'h0000, "abort_no_done");
    expect_val(2, 16'h0000, "abort_m_out");
    cycle();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      expect_val(0, 16'h0000, $sformatf("abort_rd1_r%0d", i));
      expect_val(1, 16'h0000, $sformatf("abort_rd2_r%0d", 7 - i));
      cycle();
    end
    expect_val(5, 16'd4, "done_count_final");
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors != 0 || checks < 12) begin
      $display("FAIL summary: got errors=%0d checks=%0d expected errors=0 checks>=12", errors, checks);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
